// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter and its result FIFOs.
package cdb_pkg;

  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_W-1:0]  rob_id;
    logic [DATA_W-1:0] value;
  } cdb_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Per-producer result queue: circular buffer with a registered occupancy count.
// Frozen while rdy_in is low; flush empties it and discards any same-cycle push.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             active;
  logic             do_push;
  logic             do_pop;

  assign active         = rdy_in && !flush;
  assign empty          = (count == '0);
  assign full           = (count == FULL_CNT);
  assign head           = mem[rd_ptr];
  // A push against a full queue is dropped even when a pop frees a slot on the same edge.
  assign do_push        = active && push && !full;
  assign do_pop         = active && pop && !empty;
  assign overflow_pulse = active && push && full;

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that broadcasts one ALU or LSB result per cycle on the CDB.
// Each producer queues results in its own result_fifo; the heads compete for the bus.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              _clear,
  input  logic              _alu_res_ready,
  input  logic [ROB_W-1:0]  _alu_res_rob_id,
  input  logic [DATA_W-1:0] _alu_res_value,
  output logic              _alu_res_full,
  input  logic              _lsb_res_ready,
  input  logic [ROB_W-1:0]  _lsb_res_rob_id,
  input  logic [DATA_W-1:0] _lsb_res_value,
  output logic              _lsb_res_full,
  output logic              _cdb_ready,
  output logic [ROB_W-1:0]  _cdb_rob_id,
  output logic [DATA_W-1:0] _cdb_value,
  output logic              _cdb_src,
  output logic              _overflow
);

  localparam int ENTRY_W = $bits(cdb_entry_t);

  cdb_entry_t alu_push_entry;
  cdb_entry_t lsb_push_entry;
  cdb_entry_t alu_head;
  cdb_entry_t lsb_head;
  cdb_entry_t grant_entry;
  logic       alu_empty;
  logic       lsb_empty;
  logic       alu_ovf;
  logic       lsb_ovf;
  logic       alu_pop;
  logic       lsb_pop;
  logic       grant_valid;
  logic       grant_src;
  logic       last_grant;

  assign alu_push_entry = '{rob_id: _alu_res_rob_id, value: _alu_res_value};
  assign lsb_push_entry = '{rob_id: _lsb_res_rob_id, value: _lsb_res_value};

  result_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (_clear),
    .push           (_alu_res_ready),
    .din            (alu_push_entry),
    .pop            (alu_pop),
    .head           (alu_head),
    .empty          (alu_empty),
    .full           (_alu_res_full),
    .overflow_pulse (alu_ovf)
  );

  result_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_lsb_fifo (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (_clear),
    .push           (_lsb_res_ready),
    .din            (lsb_push_entry),
    .pop            (lsb_pop),
    .head           (lsb_head),
    .empty          (lsb_empty),
    .full           (_lsb_res_full),
    .overflow_pulse (lsb_ovf)
  );

  // On contention the source that did not win last time gets the bus.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    if (rdy_in && !_clear) begin
      if (!alu_empty && !lsb_empty) begin
        grant_valid = 1'b1;
        grant_src   = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
      end else if (!alu_empty) begin
        grant_valid = 1'b1;
        grant_src   = SRC_ALU;
      end else if (!lsb_empty) begin
        grant_valid = 1'b1;
        grant_src   = SRC_LSB;
      end
    end
  end

  assign alu_pop     = grant_valid && (grant_src == SRC_ALU);
  assign lsb_pop     = grant_valid && (grant_src == SRC_LSB);
  assign grant_entry = (grant_src == SRC_LSB) ? lsb_head : alu_head;

  assign _cdb_ready  = grant_valid;
  assign _cdb_rob_id = grant_valid ? grant_entry.rob_id : '0;
  assign _cdb_value  = grant_valid ? grant_entry.value : '0;
  assign _cdb_src    = grant_valid && grant_src;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_grant <= SRC_LSB;
      _overflow  <= 1'b0;
    end else begin
      if (grant_valid) begin
        last_grant <= grant_src;
      end
      if (alu_ovf || lsb_ovf) begin
        _overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: arbitration order, backpressure,
// pause, flush, pointer wrap and asynchronous reset.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              clear;
  logic              alu_ready;
  logic [ROB_W-1:0]  alu_rob;
  logic [DATA_W-1:0] alu_val;
  logic              alu_full;
  logic              lsb_ready;
  logic [ROB_W-1:0]  lsb_rob;
  logic [DATA_W-1:0] lsb_val;
  logic              lsb_full;
  logic              cdb_ready;
  logic [ROB_W-1:0]  cdb_rob;
  logic [DATA_W-1:0] cdb_val;
  logic              cdb_src;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  int t3_rob [12] = '{1, 16, 2, 17, 3, 18, 4, 19, 5, 6, 7, 0};
  int t3_src [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};

  cdb_arbiter #(.DEPTH(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    ._clear          (clear),
    ._alu_res_ready  (alu_ready),
    ._alu_res_rob_id (alu_rob),
    ._alu_res_value  (alu_val),
    ._alu_res_full   (alu_full),
    ._lsb_res_ready  (lsb_ready),
    ._lsb_res_rob_id (lsb_rob),
    ._lsb_res_value  (lsb_val),
    ._lsb_res_full   (lsb_full),
    ._cdb_ready      (cdb_ready),
    ._cdb_rob_id     (cdb_rob),
    ._cdb_value      (cdb_val),
    ._cdb_src        (cdb_src),
    ._overflow       (overflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_cdb(input string tag, input logic v, input int rob, input logic src);
    logic [DATA_W-1:0] exp_val;
    exp_val = v ? ((src ? 32'h2000 : 32'h1000) + DATA_W'(rob)) : '0;
    check($sformatf("%s.ready", tag), 64'(cdb_ready), 64'(v));
    check($sformatf("%s.rob", tag), 64'(cdb_rob), v ? 64'(rob) : 64'd0);
    check($sformatf("%s.value", tag), 64'(cdb_val), 64'(exp_val));
    check($sformatf("%s.src", tag), 64'(cdb_src), v ? 64'(src) : 64'd0);
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_alu(input logic en, input int rob);
    alu_ready = en;
    alu_rob   = ROB_W'(rob);
    alu_val   = 32'h1000 + DATA_W'(rob);
  endtask

  task automatic drive_lsb(input logic en, input int rob);
    lsb_ready = en;
    lsb_rob   = ROB_W'(rob);
    lsb_val   = 32'h2000 + DATA_W'(rob);
  endtask

  task automatic do_reset();
    rdy_in = 1'b1;
    clear  = 1'b0;
    drive_alu(1'b0, 0);
    drive_lsb(1'b0, 0);
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
    cycle();
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    clear  = 1'b0;
    drive_alu(1'b0, 0);
    drive_lsb(1'b0, 0);
    #1;
    check_cdb("reset", 1'b0, 0, 1'b0);
    check("reset.alu_full", 64'(alu_full), 64'd0);
    check("reset.lsb_full", 64'(lsb_full), 64'd0);
    check("reset.overflow", 64'(overflow), 64'd0);
    #2;
    rst_in = 1'b1;
    cycle();

    // Single ALU result, one-cycle latency, no same-cycle bypass
    alu_ready = 1'b1; alu_rob = 5'd3; alu_val = 32'h11;
    #1;
    check("t1.no_bypass", 64'(cdb_ready), 64'd0);
    cycle();
    drive_alu(1'b0, 0);
    #1;
    check("t1.ready", 64'(cdb_ready), 64'd1);
    check("t1.rob", 64'(cdb_rob), 64'd3);
    check("t1.value", 64'(cdb_val), 64'h11);
    check("t1.src", 64'(cdb_src), 64'd0);
    cycle();
    check_cdb("t1.idle", 1'b0, 0, 1'b0);

    // Simultaneous pushes: ALU wins first after reset, then strict alternation
    do_reset();
    drive_alu(1'b1, 1);
    drive_lsb(1'b1, 2);
    cycle();
    drive_alu(1'b0, 0);
    drive_lsb(1'b0, 0);
    #1;
    check_cdb("t2.first", 1'b1, 1, 1'b0);
    cycle();
    check_cdb("t2.second", 1'b1, 2, 1'b1);
    cycle();
    check_cdb("t2.idle", 1'b0, 0, 1'b0);
    drive_alu(1'b1, 10);
    drive_lsb(1'b1, 20);
    cycle();
    for (int i = 0; i < 6; i++) begin
      drive_alu(i < 2, 11 + i);
      drive_lsb(i < 2, 21 + i);
      #1;
      check_cdb($sformatf("t2.alt%0d", i), 1'b1, ((i % 2) != 0 ? 20 : 10) + i / 2, (i % 2) != 0);
      cycle();
    end
    drive_alu(1'b0, 0);
    drive_lsb(1'b0, 0);
    #1;
    check_cdb("t2.drained", 1'b0, 0, 1'b0);

    // ALU outpaces its share of the bus until full; the next push is dropped
    do_reset();
    drive_alu(1'b1, 1);
    drive_lsb(1'b1, 16);
    cycle();
    for (int c = 1; c <= 12; c++) begin
      drive_alu(c <= 7, c + 1);
      drive_lsb((c <= 6) && (c % 2 == 0), 16 + c / 2);
      #1;
      check_cdb($sformatf("t3.c%0d", c), t3_rob[c-1] != 0, t3_rob[c-1], t3_src[c-1] != 0);
      if (c == 6 || c == 7) begin
        check($sformatf("t3.alu_full%0d", c), 64'(alu_full), 64'(c == 7));
      end
      if (c == 7 || c == 8) begin
        check($sformatf("t3.overflow%0d", c), 64'(overflow), 64'(c == 8));
      end
      cycle();
    end
    check("t3.overflow_sticky", 64'(overflow), 64'd1);

    // Pause: nothing moves while rdy_in is low, pushes are ignored
    do_reset();
    drive_alu(1'b1, 1);
    drive_lsb(1'b1, 2);
    cycle();
    rdy_in = 1'b0;
    drive_alu(1'b1, 9);
    drive_lsb(1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_cdb($sformatf("t4.paused%0d", k), 1'b0, 0, 1'b0);
      cycle();
    end
    rdy_in = 1'b1;
    drive_alu(1'b0, 0);
    #1;
    check_cdb("t4.resume0", 1'b1, 1, 1'b0);
    cycle();
    check_cdb("t4.resume1", 1'b1, 2, 1'b1);
    cycle();
    check_cdb("t4.empty", 1'b0, 0, 1'b0);

    // Flush with ALU=2, LSB=1 and a pending LSB push
    do_reset();
    drive_alu(1'b1, 1);
    drive_lsb(1'b1, 11);
    cycle();
    drive_alu(1'b1, 2);
    drive_lsb(1'b0, 0);
    #1;
    check_cdb("t5.pre0", 1'b1, 1, 1'b0);
    cycle();
    drive_alu(1'b1, 3);
    drive_lsb(1'b1, 12);
    #1;
    check_cdb("t5.pre1", 1'b1, 11, 1'b1);
    cycle();
    clear = 1'b1;
    drive_alu(1'b0, 0);
    drive_lsb(1'b1, 13);
    #1;
    check_cdb("t5.clear", 1'b0, 0, 1'b0);
    cycle();
    clear = 1'b0;
    drive_lsb(1'b0, 0);
    #1;
    check_cdb("t5.after", 1'b0, 0, 1'b0);
    check("t5.overflow", 64'(overflow), 64'd0);
    drive_alu(1'b1, 20);
    drive_lsb(1'b1, 21);
    cycle();
    drive_alu(1'b0, 0);
    drive_lsb(1'b0, 0);
    #1;
    check_cdb("t5.rr0", 1'b1, 20, 1'b0);
    cycle();
    check_cdb("t5.rr1", 1'b1, 21, 1'b1);

    // LSB stream through the wrap point
    do_reset();
    drive_lsb(1'b1, 1);
    cycle();
    for (int c = 1; c <= 9; c++) begin
      drive_lsb(c < 9, c + 1);
      #1;
      check_cdb($sformatf("t6.c%0d", c), 1'b1, c, 1'b1);
      check($sformatf("t6.full%0d", c), 64'(lsb_full), 64'd0);
      cycle();
    end
    check_cdb("t6.empty", 1'b0, 0, 1'b0);

    // Asynchronous reset during a broadcast
    do_reset();
    drive_alu(1'b1, 7);
    cycle();
    drive_alu(1'b0, 0);
    #1;
    check_cdb("t7.before", 1'b1, 7, 1'b0);
    rst_in = 1'b0;
    #1;
    check_cdb("t7.in_reset", 1'b0, 0, 1'b0);
    #1;
    rst_in = 1'b1;
    cycle();
    check_cdb("t7.after", 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
